common_stream_fifo_ctrl: RTL and testbench

- Single-clock streaming FIFO controller that sits directly in front of and behind common_simple_dual_port_ram.
- Turns a valid/ready input stream into RAM writes and issues RAM reads.
- Absorbs the RAM's 1- or 2-cycle read latency in a small output skid buffer, so the consumer sees a registered valid/ready stream at full throughput.
- Used for line buffering and rate decoupling in the vision pipeline.

---
 rtl/common_stream_fifo_ctrl_if.sv | 45 ++++
 rtl/common_stream_fifo_ctrl.sv | 134 +++++++++++++
 tb/tb_common_stream_fifo_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/common_stream_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : common_stream_fifo_ctrl_if
// Purpose  : Bundles the stream handshakes and the RAM port of the streaming
//            FIFO controller into one interface.
// Signals  : s_valid/s_ready/s_data       - producer stream into the FIFO
//            m_valid/m_ready/m_data       - consumer stream out of the FIFO
//            count                        - words held (RAM + in flight + skid)
//            ram_we/ram_waddr/ram_wdata   - write port of the attached RAM
//            ram_re/ram_raddr/ram_rdata   - read port of the attached RAM
// Modports : slave  - the FIFO controller itself
//            master - its surroundings (producer, consumer and RAM)
// Revision : 1.0 - initial release
// ============================================================================
interface common_stream_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [ADDR_WIDTH+1:0] count;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  s_valid, s_data, m_ready, ram_rdata,
    output s_ready, m_valid, m_data, count,
           ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
  );

  modport master (
    output s_valid, s_data, m_ready, ram_rdata,
    input  s_ready, m_valid, m_data, count,
           ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
  );
endinterface
`default_nettype wire

// File: rtl/common_stream_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : common_stream_fifo_ctrl
// Purpose  : Single-clock streaming FIFO controller wrapped around a simple
//            dual-port RAM. Accepted input words are written to the RAM, reads
//            are issued ahead of demand, and returning read data lands in a
//            small register skid buffer so the consumer sees a registered
//            valid/ready stream at one word per cycle.
// Ports    : clk  - clock for this block and the attached RAM
//            rstn - synchronous, active-low reset
//            bus  - stream handshakes, count and RAM port (slave modport)
// Params   : DATA_WIDTH  - word width
//            ADDR_WIDTH  - RAM address width, depth = 2**ADDR_WIDTH
//            RAM_LATENCY - RAM read latency, 1 or 2 cycles
// Revision : 1.0 - initial release
// ============================================================================
module common_stream_fifo_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 9,
  parameter int RAM_LATENCY = 2
) (
  input  wire logic                clk,
  input  wire logic                rstn,
  common_stream_fifo_ctrl_if.slave bus
);

  // Skid holds every read that can be outstanding plus the word on display.
  localparam int c_skid_depth = RAM_LATENCY + 1;
  localparam int c_scw        = $clog2(c_skid_depth + 1);
  // Storage rounded to a power of two so the push index addresses it exactly;
  // slots at or above c_skid_depth are never written.
  localparam int c_skid_slots = 2 ** c_scw;
  localparam logic [ADDR_WIDTH:0] c_depth    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [c_scw:0]      c_skid_lim = (c_scw + 1)'(c_skid_depth);

  logic [ADDR_WIDTH-1:0]  r_wptr;
  logic [ADDR_WIDTH-1:0]  r_rptr;
  logic [ADDR_WIDTH:0]    r_ram_count;
  logic [RAM_LATENCY-1:0] r_inflight;
  logic [c_scw-1:0]       r_skid_count;
  logic [DATA_WIDTH-1:0]  r_skid [c_skid_slots];
  logic                   r_m_valid;
  logic [ADDR_WIDTH+1:0]  r_count;

  logic                   w_s_ready;
  logic                   w_wr;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_has_credit;
  logic                   w_re;
  logic [c_scw-1:0]       w_inflight_n;
  logic [c_scw-1:0]       w_inflight_nxt_n;
  logic [c_scw-1:0]       w_skid_count_nxt;
  logic [c_scw-1:0]       w_push_idx;
  logic [RAM_LATENCY-1:0] w_inflight_nxt;
  logic [ADDR_WIDTH:0]    w_ram_count_nxt;

  function automatic logic [c_scw-1:0] f_ones(input logic [RAM_LATENCY-1:0] v);
    logic [c_scw-1:0] n;
    n = '0;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      n = n + c_scw'(v[i]);
    end
    return n;
  endfunction

  always_comb begin
    // Full is judged on registered occupancy only: a read issued this cycle
    // does not make room for a write in the same cycle.
    w_s_ready    = rstn & (r_ram_count < c_depth);
    w_wr         = bus.s_valid & w_s_ready;
    w_pop        = r_m_valid & bus.m_ready;
    w_push       = r_inflight[RAM_LATENCY-1];
    w_inflight_n = f_ones(r_inflight);
    // A read may be issued while the skid plus outstanding reads leave a free
    // slot, or when a pop this cycle frees one.
    w_has_credit = ({1'b0, w_inflight_n} + {1'b0, r_skid_count}) < c_skid_lim;
    w_re         = rstn & (r_ram_count != '0) & (w_has_credit | w_pop);

    w_inflight_nxt   = RAM_LATENCY'({r_inflight, w_re});
    w_inflight_nxt_n = f_ones(w_inflight_nxt);
    w_skid_count_nxt = r_skid_count + c_scw'(w_push) - c_scw'(w_pop);
    // Returning data goes behind the words that remain after this cycle's pop.
    w_push_idx       = r_skid_count - c_scw'(w_pop);
    w_ram_count_nxt  = r_ram_count + (ADDR_WIDTH + 1)'(w_wr) - (ADDR_WIDTH + 1)'(w_re);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_ram_count  <= '0;
      r_inflight   <= '0;
      r_skid_count <= '0;
      r_m_valid    <= 1'b0;
      r_count      <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + ADDR_WIDTH'(1);
      if (w_re) r_rptr <= r_rptr + ADDR_WIDTH'(1);
      r_ram_count  <= w_ram_count_nxt;
      r_inflight   <= w_inflight_nxt;
      r_skid_count <= w_skid_count_nxt;
      r_m_valid    <= (w_skid_count_nxt != '0);
      r_count      <= (ADDR_WIDTH + 2)'(w_ram_count_nxt)
                    + (ADDR_WIDTH + 2)'(w_inflight_nxt_n)
                    + (ADDR_WIDTH + 2)'(w_skid_count_nxt);
    end
  end

  // Skid storage: entry 0 is the head. A pop shifts everything down; a push
  // written later in the block takes priority over the shift at its slot.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      for (int i = 0; i < c_skid_depth - 1; i++) begin
        r_skid[i] <= r_skid[i+1];
      end
    end
    if (w_push) begin
      r_skid[w_push_idx] <= bus.ram_rdata;
    end
  end

  assign bus.s_ready   = w_s_ready;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = r_skid[0];
  assign bus.count     = r_count;
  assign bus.ram_we    = w_wr;
  assign bus.ram_waddr = r_wptr;
  assign bus.ram_wdata = bus.s_data;
  assign bus.ram_re    = w_re;
  assign bus.ram_raddr = r_rptr;

endmodule
`default_nettype wire

// File: tb/tb_common_stream_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_common_stream_fifo_ctrl
// Purpose  : Self-checking bench for common_stream_fifo_ctrl. Three instances:
//            cfg0 ADDR_WIDTH=4 RAM_LATENCY=2, cfg1 ADDR_WIDTH=3 RAM_LATENCY=1,
//            cfg2 ADDR_WIDTH=3 RAM_LATENCY=2, each with a behavioural RAM and
//            a queue model of the words it must hold.
// Revision : 1.0 - initial release
// ============================================================================
module tb_common_stream_fifo_ctrl;

  logic       clk;
  logic [2:0] rstn;
  logic [2:0] s_valid;
  logic [2:0] m_ready;
  logic [7:0] s_data [3];

  logic [2:0] ob_s_ready;
  logic [2:0] ob_m_valid;
  logic [2:0] ob_ram_we;
  logic [2:0] ob_ram_re;
  logic [7:0] ob_m_data [3];
  int         ob_count [3];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int c, input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL cfg%0d %s: got %0d expected %0d", c, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int LAT = (g == 1) ? 1 : 2;
    localparam int AW  = (g == 0) ? 4 : 3;
    localparam int DEP = 1 << AW;

    common_stream_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(AW)) ifc ();

    common_stream_fifo_ctrl #(
      .DATA_WIDTH(8), .ADDR_WIDTH(AW), .RAM_LATENCY(LAT)
    ) u_dut (
      .clk (clk),
      .rstn(rstn[g]),
      .bus (ifc.slave)
    );

    assign ifc.s_valid   = s_valid[g];
    assign ifc.s_data    = s_data[g];
    assign ifc.m_ready   = m_ready[g];
    assign ob_s_ready[g] = ifc.s_ready;
    assign ob_m_valid[g] = ifc.m_valid;
    assign ob_ram_we[g]  = ifc.ram_we;
    assign ob_ram_re[g]  = ifc.ram_re;
    assign ob_m_data[g]  = ifc.m_data;
    assign ob_count[g]   = int'(ifc.count);

    // Behavioural RAM with LAT cycles from ram_re to valid ram_rdata.
    logic [7:0] mem [DEP];
    logic [7:0] rpipe [LAT];
    always @(posedge clk) begin
      if (ifc.ram_we) mem[ifc.ram_waddr] <= ifc.ram_wdata;
      if (ifc.ram_re) rpipe[0] <= mem[ifc.ram_raddr];
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ifc.ram_rdata = rpipe[LAT-1];

    // Model: queue of held words, plus counts of RAM writes/reads since reset.
    int         q[$];
    int         wr_n = 0;
    int         rd_n = 0;
    logic       hold = 1'b0;
    logic [7:0] held = '0;
    always @(negedge clk) begin
      if (rstn[g]) begin
        chk(g, "count", int'(ifc.count), q.size());
        if (ifc.m_valid) begin
          if (q.size() == 0) chk(g, "spurious_m_valid", 1, 0);
          else               chk(g, "m_data", int'(ifc.m_data), q[0]);
          if (hold) chk(g, "m_data_stable", int'(ifc.m_data), int'(held));
        end
        if (q.size() < DEP) chk(g, "s_ready_room", int'(ifc.s_ready), 1);
        chk(g, "ram_we", int'(ifc.ram_we), int'(ifc.s_valid & ifc.s_ready));
        if (ifc.ram_we) begin
          chk(g, "ram_waddr", int'(ifc.ram_waddr), wr_n % DEP);
          chk(g, "ram_wdata", int'(ifc.ram_wdata), int'(ifc.s_data));
        end
        if (ifc.ram_re) begin
          chk(g, "ram_raddr", int'(ifc.ram_raddr), rd_n % DEP);
          chk(g, "read_after_write", int'(rd_n < wr_n), 1);
        end
        hold = ifc.m_valid & ~ifc.m_ready;
        held = ifc.m_data;
        if (ifc.m_valid && ifc.m_ready && q.size() > 0) void'(q.pop_front());
        if (ifc.ram_we) begin
          q.push_back(int'(ifc.s_data));
          wr_n++;
        end
        if (ifc.ram_re) rd_n++;
      end else begin
        chk(g, "rst_s_ready", int'(ifc.s_ready), 0);
        chk(g, "rst_ram_we", int'(ifc.ram_we), 0);
        chk(g, "rst_ram_re", int'(ifc.ram_re), 0);
        q.delete();
        wr_n = 0;
        rd_n = 0;
        hold = 1'b0;
      end
    end
  end

  // Tasks are entered and left 1 time unit after a rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic fill(input int c, input int base, input int n,
                      output int acc, output int hs0, output int mv0, output int mvd);
    acc = 0; hs0 = -1; mv0 = -1; mvd = -1;
    m_ready[c] = 1'b0;
    s_valid[c] = 1'b1;
    s_data[c]  = 8'(base);
    for (int t = 0; t < 4 * n + 20 && acc < n; t++) begin
      look();
      if (ob_m_valid[c] && mv0 < 0) begin
        mv0 = t;
        mvd = int'(ob_m_data[c]);
      end
      if (ob_s_ready[c]) begin
        if (hs0 < 0) hs0 = t;
        acc++;
      end
      nxt();
      s_data[c] = 8'(base + acc);
    end
  endtask

  task automatic drain_all(input int c);
    int t;
    s_valid[c] = 1'b0;
    m_ready[c] = 1'b1;
    for (t = 0; t < 200; t++) begin
      look();
      if (ob_count[c] == 0 && !ob_m_valid[c]) break;
      nxt();
    end
    chk(c, "drain_timeout", int'(t < 200), 1);
    nxt();
  endtask

  task automatic stream(input int c);
    int lat, first, outs, gaps, stalls, order_err;
    lat = (c == 1) ? 1 : 2;
    first = -1; outs = 0; gaps = 0; stalls = 0; order_err = 0;
    s_valid[c] = 1'b1;
    m_ready[c] = 1'b1;
    s_data[c]  = 8'd0;
    for (int t = 0; t < 100; t++) begin
      look();
      if (!ob_s_ready[c]) stalls++;
      if (ob_m_valid[c]) begin
        if (first < 0) first = t;
        if (ob_m_data[c] != 8'(outs)) order_err++;
        outs++;
      end else if (first >= 0) begin
        gaps++;
      end
      nxt();
      s_data[c] = 8'(t + 1);
    end
    chk(c, "stream_first_out", first, 2 + lat);
    chk(c, "stream_gaps", gaps, 0);
    chk(c, "stream_stalls", stalls, 0);
    chk(c, "stream_words", outs, 100 - 2 - lat);
    chk(c, "stream_order", order_err, 0);
    drain_all(c);
  endtask

  task automatic backpressure(input int c, input int n);
    int sent, recv;
    sent = 0; recv = 0;
    s_valid[c] = ($urandom_range(0, 99) < 70);
    s_data[c]  = 8'($urandom);
    m_ready[c] = ($urandom_range(0, 99) < 50);
    for (int t = 0; t < 40000 && recv < n; t++) begin
      look();
      if (s_valid[c] && ob_s_ready[c]) sent++;
      if (ob_m_valid[c] && m_ready[c]) recv++;
      nxt();
      s_valid[c] = (sent < n) && ($urandom_range(0, 99) < 70);
      s_data[c]  = 8'($urandom);
      m_ready[c] = ($urandom_range(0, 99) < 50);
    end
    chk(c, "bp_sent", sent, n);
    chk(c, "bp_recv", recv, n);
    drain_all(c);
  endtask

  initial begin
    int acc, hs0, mv0, mvd, n, writes, first_d;
    logic acc_now;
    rstn    = '0;
    s_valid = '0;
    m_ready = '0;
    for (int c = 0; c < 3; c++) s_data[c] = 8'd0;
    repeat (3) nxt();

    // Reset state, then the first cycle after release.
    look();
    for (int c = 0; c < 3; c++) begin
      chk(c, "reset_m_valid", int'(ob_m_valid[c]), 0);
      chk(c, "reset_count", ob_count[c], 0);
    end
    nxt();
    rstn = '1;
    look();
    for (int c = 0; c < 3; c++) chk(c, "release_s_ready", int'(ob_s_ready[c]), 1);
    nxt();

    // Fill 19 words (16 RAM + 3 skid) with the consumer stalled.
    fill(0, 8'h01, 19, acc, hs0, mv0, mvd);
    chk(0, "fill_accepted", acc, 19);
    chk(0, "fill_first_hs", hs0, 0);
    chk(0, "fill_latency", mv0 - hs0, 4);
    chk(0, "fill_first_data", mvd, 8'h01);
    for (int t = 0; t < 3; t++) begin
      look();
      chk(0, "full_s_ready", int'(ob_s_ready[0]), 0);
      chk(0, "full_count", ob_count[0], 19);
      nxt();
    end

    // Drain from full: 0x01..0x13 on consecutive cycles.
    s_valid[0] = 1'b0;
    m_ready[0] = 1'b1;
    n = 0;
    for (int t = 0; t < 30; t++) begin
      look();
      if (t == 0) chk(0, "drain_s_ready_full", int'(ob_s_ready[0]), 0);
      if (t == 1) chk(0, "drain_s_ready_back", int'(ob_s_ready[0]), 1);
      if (ob_m_valid[0]) begin
        chk(0, "drain_data", int'(ob_m_data[0]), n + 1);
        chk(0, "drain_slot", t, n);
        n++;
      end
      nxt();
    end
    chk(0, "drain_words", n, 19);
    look();
    chk(0, "drained_m_valid", int'(ob_m_valid[0]), 0);
    chk(0, "drained_count", ob_count[0], 0);
    nxt();

    // Full boundary: refill, then a single consumer pulse with s_valid held.
    fill(0, 8'h21, 19, acc, hs0, mv0, mvd);
    chk(0, "refill_accepted", acc, 19);
    m_ready[0] = 1'b1;
    look();
    chk(0, "bnd_pop_valid", int'(ob_m_valid[0]), 1);
    chk(0, "bnd_no_write_in_pop", int'(ob_ram_we[0]), 0);
    nxt();
    m_ready[0] = 1'b0;
    writes = 0;
    for (int t = 0; t < 8; t++) begin
      look();
      if (ob_ram_we[0]) writes++;
      nxt();
    end
    chk(0, "bnd_single_write", writes, 1);
    look();
    chk(0, "bnd_count", ob_count[0], 19);
    nxt();
    drain_all(0);

    // Reset with five words held and reads outstanding.
    fill(0, 8'h41, 5, acc, hs0, mv0, mvd);
    chk(0, "pre_rst_accepted", acc, 5);
    s_valid[0] = 1'b0;
    rstn[0]    = 1'b0;
    look();
    chk(0, "pre_rst_count", ob_count[0], 5);
    nxt();
    rstn[0] = 1'b1;
    look();
    chk(0, "post_rst_m_valid", int'(ob_m_valid[0]), 0);
    chk(0, "post_rst_count", ob_count[0], 0);
    chk(0, "post_rst_ram_re", int'(ob_ram_re[0]), 0);
    nxt();
    for (int t = 0; t < 4; t++) begin
      look();
      chk(0, "post_rst_no_late", int'(ob_m_valid[0]), 0);
      nxt();
    end
    s_valid[0] = 1'b1;
    s_data[0]  = 8'hAA;
    m_ready[0] = 1'b1;
    first_d = -1;
    for (int t = 0; t < 20; t++) begin
      look();
      acc_now = s_valid[0] & ob_s_ready[0];
      if (ob_m_valid[0] && first_d < 0) first_d = int'(ob_m_data[0]);
      nxt();
      if (acc_now) s_valid[0] = 1'b0;
    end
    chk(0, "post_rst_first_word", first_d, 8'hAA);
    drain_all(0);

    for (int c = 0; c < 3; c++) stream(c);
    for (int c = 0; c < 3; c++) backpressure(c, 2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
